// File: rtl/cmos_frame_gate.sv
// Gates a CMOS capture stream into the frame-buffer write port: settles after sensor
// config, then forwards whole frames with decimation, freeze and single-frame snapshot.
module cmos_frame_gate #(
    parameter int SETTLE_FRAMES = 10,
    parameter int DW            = 16
) (
    input  logic          cmos_pclk,
    input  logic          I_rst_n,
    input  logic          I_cfg_done,
    input  logic          I_vs,
    input  logic          I_de,
    input  logic [DW-1:0] I_data,
    input  logic          I_freeze,
    input  logic          I_snap,
    input  logic [3:0]    I_skip,
    output logic          O_vs,
    output logic          O_de,
    output logic [DW-1:0] O_data,
    output logic [1:0]    O_state,
    output logic [15:0]   O_frame_cnt,
    output logic          O_wr_active
);

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        SETTLE   = 2'd1,
        RUN      = 2'd2,
        FROZEN   = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_N = 16'(SETTLE_FRAMES);

    state_t        state;
    logic          cfg_m, cfg_s, vs_r;
    logic          rise, fall;
    logic          grant, grant_dec, g;
    logic          snap_pending;
    logic [3:0]    skip_cnt;
    logic [15:0]   settle_cnt, frame_cnt;
    logic          vs_p1, de_p1;
    logic [DW-1:0] data_p1;

    assign rise = I_vs & ~vs_r;
    assign fall = ~I_vs & vs_r;

    always_comb begin
        grant_dec = 1'b0;
        case (state)
            RUN:     grant_dec = (skip_cnt == 4'd0);
            FROZEN:  grant_dec = snap_pending | I_snap;
            default: grant_dec = 1'b0;
        endcase
    end

    // A dropped config kills forwarding immediately rather than waiting for the state to catch up.
    assign g = cfg_s & (rise ? grant_dec : grant);

    // ---- stage p0: config sync, frame edge detect, frame counter ----
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cfg_m     <= 1'b0;
            cfg_s     <= 1'b0;
            vs_r      <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            cfg_m <= I_cfg_done;
            cfg_s <= cfg_m;
            vs_r  <= I_vs;
            if (fall)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state        <= WAIT_CFG;
            grant        <= 1'b0;
            snap_pending <= 1'b0;
            skip_cnt     <= 4'd0;
            settle_cnt   <= 16'd0;
        end else if (!cfg_s) begin
            state        <= WAIT_CFG;
            grant        <= 1'b0;
            snap_pending <= 1'b0;
            skip_cnt     <= 4'd0;
        end else begin
            if (rise)
                grant <= grant_dec;
            else if (fall)
                grant <= 1'b0;

            if (rise && state == RUN)
                skip_cnt <= (skip_cnt == 4'd0) ? I_skip : skip_cnt - 4'd1;

            // A snap arriving on the rise cycle is consumed by that same frame.
            if (state == FROZEN) begin
                if (rise && grant_dec)
                    snap_pending <= 1'b0;
                else if (I_snap)
                    snap_pending <= 1'b1;
            end

            case (state)
                WAIT_CFG: begin
                    state      <= SETTLE;
                    settle_cnt <= 16'd0;
                end
                SETTLE: if (fall) begin
                    settle_cnt <= settle_cnt + 16'd1;
                    if (settle_cnt + 16'd1 >= SETTLE_N) begin
                        state    <= RUN;
                        skip_cnt <= 4'd0;
                    end
                end
                RUN: if (fall && I_freeze)
                    state <= FROZEN;
                FROZEN: if (fall && !I_freeze) begin
                    state    <= RUN;
                    skip_cnt <= 4'd0;
                end
                default: state <= WAIT_CFG;
            endcase
        end
    end

    // ---- stage p1: gated output stream ----
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_p1   <= 1'b0;
            de_p1   <= 1'b0;
            data_p1 <= '0;
        end else begin
            vs_p1   <= I_vs & g;
            de_p1   <= I_de & g;
            data_p1 <= g ? I_data : '0;
        end
    end

    assign O_vs        = vs_p1;
    assign O_de        = de_p1;
    assign O_data      = data_p1;
    assign O_wr_active = grant;
    assign O_state     = state;
    assign O_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_cmos_frame_gate.sv
// Bench for cmos_frame_gate: per-cycle expected output words are queued as stimulus is
// driven and compared one clock later; scenario tasks add state/counter checks.
module tb_cmos_frame_gate;
    localparam int DW = 16;
    localparam int EW = DW + 3;

    logic          cmos_pclk = 1'b0;
    logic          I_rst_n, I_cfg_done, I_vs, I_de, I_freeze, I_snap;
    logic [DW-1:0] I_data;
    logic [3:0]    I_skip;
    logic          O_vs, O_de, O_wr_active;
    logic [DW-1:0] O_data;
    logic [1:0]    O_state;
    logic [15:0]   O_frame_cnt;

    always #5 cmos_pclk = ~cmos_pclk;

    cmos_frame_gate #(.SETTLE_FRAMES(3), .DW(DW)) dut (
        .cmos_pclk  (cmos_pclk),
        .I_rst_n    (I_rst_n),
        .I_cfg_done (I_cfg_done),
        .I_vs       (I_vs),
        .I_de       (I_de),
        .I_data     (I_data),
        .I_freeze   (I_freeze),
        .I_snap     (I_snap),
        .I_skip     (I_skip),
        .O_vs       (O_vs),
        .O_de       (O_de),
        .O_data     (O_data),
        .O_state    (O_state),
        .O_frame_cnt(O_frame_cnt),
        .O_wr_active(O_wr_active)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          exp_fc = 0;
    bit          sb_hold = 1'b1;
    bit          have    = 1'b0;
    logic [EW-1:0] q[$];
    logic [EW-1:0] cur;

    // Scoreboard: entry queued with the inputs is due after the next rising edge.
    always @(posedge cmos_pclk) begin
        if (!sb_hold && q.size() > 0) begin
            cur  = q.pop_front();
            have = 1'b1;
        end else begin
            have = 1'b0;
        end
    end

    always @(negedge cmos_pclk) begin
        if (have && !sb_hold) begin
            n_chk++;
            if ({O_vs, O_de, O_wr_active, O_data} !== cur) begin
                n_fail++;
                $display("FAIL stream t=%0t got vs/de/wr/data=%b/%b/%b/%h exp %b/%b/%b/%h",
                         $time, O_vs, O_de, O_wr_active, O_data,
                         cur[EW-1], cur[EW-2], cur[EW-3], cur[DW-1:0]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_de(input int i);
        return (i >= 2 && i < 18 && ((i - 2) % 8) < 6);
    endfunction

    task automatic drive(input logic vs, input logic de, input bit g, input bit snap);
        logic [DW-1:0] d;
        @(posedge cmos_pclk);
        #1;
        d      = DW'($urandom);
        I_vs   = vs;
        I_de   = de;
        I_data = d;
        I_snap = snap;
        if (!sb_hold)
            q.push_back({vs & g, de & g, vs & g, g ? d : {DW{1'b0}}});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Granted frames also pass data on the fall cycle, since grant still holds there.
    task automatic send_frame(input bit fwd, input int freeze_at, input bit snap_rise);
        for (int i = 0; i < 20; i++) begin
            if (i == freeze_at)
                I_freeze = 1'b1;
            drive(1'b1, frame_de(i), fwd, snap_rise && i == 0);
        end
        drive(1'b0, 1'b0, fwd, 1'b0);
        exp_fc++;
        idle(3);
    endtask

    task automatic test_reset();
        I_rst_n = 1'b0; I_cfg_done = 1'b0; I_vs = 1'b0; I_de = 1'b0;
        I_data = '0; I_freeze = 1'b0; I_snap = 1'b0; I_skip = 4'd0;
        repeat (3) @(posedge cmos_pclk);
        @(negedge cmos_pclk);
        n_chk++; if (O_vs !== 1'b0) begin n_fail++; $display("FAIL reset_vs got %b exp 0", O_vs); end
        n_chk++; if (O_de !== 1'b0) begin n_fail++; $display("FAIL reset_de got %b exp 0", O_de); end
        n_chk++; if (O_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", O_data); end
        n_chk++; if (O_wr_active !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b exp 0", O_wr_active); end
        n_chk++; if (O_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", O_state); end
        n_chk++; if (O_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_fcnt got %0d exp 0", O_frame_cnt); end
        @(posedge cmos_pclk);
        #1 I_rst_n = 1'b1;
        sb_hold = 1'b0;
    endtask

    task automatic test_startup();
        I_cfg_done = 1'b1;
        idle(4);
        n_chk++; if (O_state !== 2'd1) begin n_fail++; $display("FAIL startup_settle got %0d exp 1", O_state); end
        send_frame(1'b0, -1, 1'b0);
        n_chk++; if (O_state !== 2'd1) begin n_fail++; $display("FAIL startup_still_settle got %0d exp 1", O_state); end
        send_frame(1'b0, -1, 1'b0);
        send_frame(1'b0, -1, 1'b0);
        n_chk++; if (O_state !== 2'd2) begin n_fail++; $display("FAIL startup_run got %0d exp 2", O_state); end
        for (int f = 0; f < 3; f++) send_frame(1'b1, -1, 1'b0);
        n_chk++; if (O_frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL startup_fcnt got %0d exp %0d", O_frame_cnt, exp_fc); end
    endtask

    task automatic test_decimation();
        I_skip = 4'd2;
        for (int f = 0; f < 9; f++) send_frame(f % 3 == 0, -1, 1'b0);
        I_skip = 4'd0;
        n_chk++; if (O_frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL decim_fcnt got %0d exp %0d", O_frame_cnt, exp_fc); end
    endtask

    task automatic test_freeze();
        send_frame(1'b1, 10, 1'b0);
        n_chk++; if (O_state !== 2'd3) begin n_fail++; $display("FAIL freeze_state got %0d exp 3", O_state); end
        send_frame(1'b0, -1, 1'b0);
        send_frame(1'b0, -1, 1'b0);
        n_chk++; if (O_state !== 2'd3) begin n_fail++; $display("FAIL freeze_hold got %0d exp 3", O_state); end
    endtask

    task automatic test_snapshot();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        send_frame(1'b1, -1, 1'b0);
        send_frame(1'b0, -1, 1'b0);
        send_frame(1'b1, -1, 1'b1);
        send_frame(1'b0, -1, 1'b0);
        n_chk++; if (O_state !== 2'd3) begin n_fail++; $display("FAIL snap_state got %0d exp 3", O_state); end
    endtask

    task automatic test_unfreeze();
        I_freeze = 1'b0;
        send_frame(1'b0, -1, 1'b0);
        n_chk++; if (O_state !== 2'd2) begin n_fail++; $display("FAIL unfreeze_state got %0d exp 2", O_state); end
        send_frame(1'b1, -1, 1'b0);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) drive(1'b1, frame_de(i), 1'b1, 1'b0);
        sb_hold = 1'b1;
        q.delete();
        I_cfg_done = 1'b0;
        I_de = 1'b1;
        repeat (3) @(posedge cmos_pclk);
        @(negedge cmos_pclk);
        n_chk++; if (O_vs !== 1'b0) begin n_fail++; $display("FAIL abort_vs got %b exp 0", O_vs); end
        n_chk++; if (O_de !== 1'b0) begin n_fail++; $display("FAIL abort_de got %b exp 0", O_de); end
        n_chk++; if (O_state !== 2'd0) begin n_fail++; $display("FAIL abort_state got %0d exp 0", O_state); end
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        exp_fc++;
        idle(3);
        n_chk++; if (O_frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL abort_fcnt got %0d exp %0d", O_frame_cnt, exp_fc); end
        I_cfg_done = 1'b1;
        q.delete();
        sb_hold = 1'b0;
        idle(4);
        n_chk++; if (O_state !== 2'd1) begin n_fail++; $display("FAIL abort_resettle got %0d exp 1", O_state); end
        for (int f = 0; f < 3; f++) send_frame(1'b0, -1, 1'b0);
        n_chk++; if (O_state !== 2'd2) begin n_fail++; $display("FAIL abort_rerun got %0d exp 2", O_state); end
        send_frame(1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 6; i++) drive(1'b1, frame_de(i), 1'b1, 1'b0);
        @(negedge cmos_pclk);
        n_chk++; if (O_vs !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_vs got %b exp 1", O_vs); end
        sb_hold = 1'b1;
        q.delete();
        I_rst_n = 1'b0;
        #1;
        n_chk++;
        if ({O_vs, O_de, O_wr_active, O_data, O_state, O_frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got vs/de/wr/data/state/fcnt=%b/%b/%b/%h/%0d/%0d exp all 0",
                     O_vs, O_de, O_wr_active, O_data, O_state, O_frame_cnt);
        end
        @(posedge cmos_pclk);
        #1 I_rst_n = 1'b1;
        exp_fc  = 0;
        sb_hold = 1'b0;
        for (int i = 6; i < 12; i++) drive(1'b1, frame_de(i), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        exp_fc++;
        idle(3);
        n_chk++; if (O_frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL rstmid_fcnt got %0d exp %0d", O_frame_cnt, exp_fc); end
        n_chk++; if (O_state !== 2'd1) begin n_fail++; $display("FAIL rstmid_state got %0d exp 1", O_state); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_decimation();
        test_freeze();
        test_snapshot();
        test_unfreeze();
        test_abort();
        test_reset_midframe();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
